// File: rtl/score_pkg.sv
// Shared types, glyph geometry and glyph selection for the score overlay.
package score_pkg;

  localparam int unsigned GLYPH_W     = 8;
  localparam int unsigned GLYPH_H     = 16;
  localparam logic [3:0]  GLYPH_BLANK = 4'd10;

  typedef logic [3:0] bcd_t;
  typedef logic [7:0] glyph_addr_t;

  // Map a shadowed BCD digit to a font glyph index. Non-decimal codes render
  // blank; blank_zero additionally blanks a zero (leading-zero suppression).
  function automatic bcd_t glyph_of(bcd_t d, logic blank_zero);
    if ((d > 4'd9) || (blank_zero && (d == 4'd0))) begin
      return GLYPH_BLANK;
    end
    return d;
  endfunction

endpackage

// File: rtl/score_renderer_if.sv
// Pixel stream, score digits and overlay flags between the points counter,
// the VGA timing chain and the colour mapper.
interface score_renderer_if;
  import score_pkg::*;

  logic       frame_start;
  bcd_t       digit_1;
  bcd_t       digit_2;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       pixel_valid;
  logic       is_score;
  logic       score_valid;
  logic       blinking;

  modport master (
    output frame_start, digit_1, digit_2, DrawX, DrawY, pixel_valid,
    input  is_score, score_valid, blinking
  );

  modport slave (
    input  frame_start, digit_1, digit_2, DrawX, DrawY, pixel_valid,
    output is_score, score_valid, blinking
  );

endinterface

// File: rtl/score_font_rom.sv
// 256x8 synchronous font ROM: 16 glyphs of 16 rows, one byte per row with
// bit 7 as the leftmost column. Glyphs 0-9 are seven-segment style digits,
// everything from glyph 10 upwards (addresses 160-255) reads zero.
module score_font_rom
  import score_pkg::*;
(
  input  logic        Clk,
  input  glyph_addr_t addr,
  output logic [7:0]  data
);

  // Segment strokes inside the 8x16 cell: horizontal bars span columns 2..5,
  // vertical strokes sit in column 1 (left) or column 6 (right).
  localparam logic [7:0] BAR   = 8'h3C;
  localparam logic [7:0] LEFT  = 8'h40;
  localparam logic [7:0] RIGHT = 8'h02;

  function automatic logic [7:0] font_row(glyph_addr_t a);
    logic [6:0] seg;  // {g, f, e, d, c, b, a}
    logic [3:0] r;
    logic [7:0] bits;
    r = a[3:0];
    case (a[7:4])
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = 7'h00;
    endcase
    bits = 8'h00;
    if (seg[0] && (r inside {[4'd1:4'd2]}))   bits = bits | BAR;    // a
    if (seg[1] && (r inside {[4'd2:4'd7]}))   bits = bits | RIGHT;  // b
    if (seg[2] && (r inside {[4'd8:4'd13]}))  bits = bits | RIGHT;  // c
    if (seg[3] && (r inside {[4'd13:4'd14]})) bits = bits | BAR;    // d
    if (seg[4] && (r inside {[4'd8:4'd13]}))  bits = bits | LEFT;   // e
    if (seg[5] && (r inside {[4'd2:4'd7]}))   bits = bits | LEFT;   // f
    if (seg[6] && (r inside {[4'd7:4'd8]}))   bits = bits | BAR;    // g
    return bits;
  endfunction

  // Registered read, no reset: the consumer gates the byte with a reset valid.
  always_ff @(posedge Clk) begin
    data <= font_row(addr);
  end

endmodule

// File: rtl/score_renderer.sv
// Two-digit score overlay. Digits are snapshotted on frame_start so a frame
// never tears, rendered through a scaled 8x16 font, and flashed 4-on/4-off
// for BLINK_FRAMES frames after every value change. is_score / score_valid
// follow the pixel that produced them by two clocks.
module score_renderer
  import score_pkg::*;
#(
  parameter logic [9:0]  X_POS        = 10'd560,
  parameter logic [9:0]  Y_POS        = 10'd16,
  parameter int unsigned SCALE_SHIFT  = 1,
  parameter logic [5:0]  BLINK_FRAMES = 6'd30
) (
  input logic             Clk,
  input logic             Reset_n,
  score_renderer_if.slave bus
);

  localparam logic [9:0] CELL_W = 10'(GLYPH_W << SCALE_SHIFT);
  localparam logic [9:0] CELL_H = 10'(GLYPH_H << SCALE_SHIFT);
  localparam logic [9:0] BOX_W  = 10'((2 * GLYPH_W) << SCALE_SHIFT);

  // Frame-rate state.
  bcd_t       shadow_1_q, shadow_1_d;
  bcd_t       shadow_2_q, shadow_2_d;
  logic [5:0] blink_cnt_q, blink_cnt_d;
  logic [2:0] frame_phase_q, frame_phase_d;
  logic       changed;

  // Snapshot, change detection and flash countdown; all advance on frame_start only.
  always_comb begin
    shadow_1_d    = shadow_1_q;
    shadow_2_d    = shadow_2_q;
    blink_cnt_d   = blink_cnt_q;
    frame_phase_d = frame_phase_q;
    changed       = (bus.digit_1 != shadow_1_q) || (bus.digit_2 != shadow_2_q);
    if (bus.frame_start) begin
      shadow_1_d    = bus.digit_1;
      shadow_2_d    = bus.digit_2;
      frame_phase_d = frame_phase_q + 3'd1;
      if (changed) begin
        blink_cnt_d = BLINK_FRAMES;  // reload, never accumulate
      end else if (blink_cnt_q != 6'd0) begin
        blink_cnt_d = blink_cnt_q - 6'd1;
      end
    end
  end

  // Frame-rate state register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      shadow_1_q    <= '0;
      shadow_2_q    <= '0;
      blink_cnt_q   <= '0;
      frame_phase_q <= '0;
    end else begin
      shadow_1_q    <= shadow_1_d;
      shadow_2_q    <= shadow_2_d;
      blink_cnt_q   <= blink_cnt_d;
      frame_phase_q <= frame_phase_d;
    end
  end

  // S0: box test, cell split and glyph/row/column decode for the current pixel.
  logic [9:0]  dx, dy, cell_dx;
  logic        in_box_s0, ones_s0, suppress_s0;
  logic [2:0]  col_s0;
  logic [3:0]  row_s0;
  bcd_t        glyph_s0, tens_glyph, ones_glyph;
  glyph_addr_t rom_addr;

  // S0 decode. The >= checks keep wrapped differences left of/above the box out.
  always_comb begin
    dx          = bus.DrawX - X_POS;
    dy          = bus.DrawY - Y_POS;
    in_box_s0   = (bus.DrawX >= X_POS) && (dx < BOX_W) &&
                  (bus.DrawY >= Y_POS) && (dy < CELL_H);
    ones_s0     = (dx >= CELL_W);
    cell_dx     = ones_s0 ? (dx - CELL_W) : dx;
    col_s0      = 3'(cell_dx >> SCALE_SHIFT);
    row_s0      = 4'(dy >> SCALE_SHIFT);
    tens_glyph  = glyph_of(shadow_2_q, 1'b1);
    ones_glyph  = glyph_of(shadow_1_q, 1'b0);
    glyph_s0    = ones_s0 ? ones_glyph : tens_glyph;
    rom_addr    = {glyph_s0, row_s0};
    suppress_s0 = (blink_cnt_q != 6'd0) && frame_phase_q[2];
  end

  // S1: font read plus the side-band that must stay aligned with it.
  logic [7:0] rom_byte;
  logic       in_box_s1_q, valid_s1_q, suppress_s1_q;
  logic [2:0] col_s1_q;

  score_font_rom u_font (
    .Clk  (Clk),
    .addr (rom_addr),
    .data (rom_byte)
  );

  // S1 side-band register, launched together with the ROM address.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      in_box_s1_q   <= 1'b0;
      valid_s1_q    <= 1'b0;
      suppress_s1_q <= 1'b0;
      col_s1_q      <= '0;
    end else begin
      in_box_s1_q   <= in_box_s0;
      valid_s1_q    <= bus.pixel_valid;
      suppress_s1_q <= suppress_s0;
      col_s1_q      <= col_s0;
    end
  end

  // S2: pick the glyph bit and gate it.
  logic is_score_d, is_score_q, score_valid_q;

  // Output bit select from the registered font byte.
  always_comb begin
    is_score_d = valid_s1_q & in_box_s1_q & rom_byte[3'd7 - col_s1_q] & ~suppress_s1_q;
  end

  // Output register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      is_score_q    <= 1'b0;
      score_valid_q <= 1'b0;
    end else begin
      is_score_q    <= is_score_d;
      score_valid_q <= valid_s1_q;
    end
  end

  assign bus.is_score    = is_score_q;
  assign bus.score_valid = score_valid_q;
  assign bus.blinking    = (blink_cnt_q != 6'd0);

endmodule

// File: tb/tb_score_renderer.sv
// Directed bench for score_renderer with default geometry: box x 560..591,
// y 16..47, tens cell x 560..575, ones cell x 576..591, 2x scaling.
// Expected pixels are hand-derived from the seven-segment font layout.
module tb_score_renderer;

  logic Clk;
  logic Reset_n;
  int   n_checks;
  int   n_pass;
  logic [2:0] phase;  // bench copy of the frame phase

  score_renderer_if bus ();

  score_renderer dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic       v;
    logic       exp;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    phase   = 3'd0;
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1'b1;
  endtask

  task automatic frame(input logic [3:0] d2, input logic [3:0] d1);
    bus.digit_2     = d2;
    bus.digit_1     = d1;
    bus.frame_start = 1'b1;
    @(posedge Clk);
    #1 bus.frame_start = 1'b0;
    phase = phase + 3'd1;
  endtask

  task automatic pix_at(input logic [9:0] x, input logic [9:0] y, input logic v,
                        output logic lit, output logic sv);
    bus.DrawX       = x;
    bus.DrawY       = y;
    bus.pixel_valid = v;
    @(posedge Clk);
    #1 bus.pixel_valid = 1'b0;
    @(posedge Clk);
    #1;
    lit = bus.is_score;
    sv  = bus.score_valid;
  endtask

  // Stream every pixel of one 16x32 cell back-to-back and count lit outputs.
  task automatic scan_cell(input int x0, input int y0, output int lit);
    lit = 0;
    for (int k = 0; k <= 512; k++) begin
      if (k < 512) begin
        bus.DrawX       = 10'(x0 + (k % 16));
        bus.DrawY       = 10'(y0 + (k / 16));
        bus.pixel_valid = 1'b1;
      end else begin
        bus.pixel_valid = 1'b0;
      end
      @(posedge Clk);
      #1;
      if (k >= 1 && bus.is_score) lit++;
    end
  endtask

  initial begin
    logic lit, sv;
    int   cnt;
    n_checks = 0;
    n_pass   = 0;

    vecs[0]  = '{10'd572, 10'd24, 1'b1, 1'b1};  // tens "1", b stroke
    vecs[1]  = '{10'd562, 10'd24, 1'b1, 1'b0};  // tens "1", left column dark
    vecs[2]  = '{10'd572, 10'd36, 1'b1, 1'b1};  // tens "1", c stroke
    vecs[3]  = '{10'd578, 10'd24, 1'b1, 1'b1};  // ones "0", f stroke
    vecs[4]  = '{10'd582, 10'd30, 1'b1, 1'b0};  // ones "0", no middle bar
    vecs[5]  = '{10'd582, 10'd18, 1'b1, 1'b1};  // ones "0", top bar
    vecs[6]  = '{10'd584, 10'd44, 1'b1, 1'b1};  // ones "0", bottom bar
    vecs[7]  = '{10'd584, 10'd16, 1'b1, 1'b0};  // glyph row 0 is blank
    vecs[8]  = '{10'd576, 10'd24, 1'b1, 1'b0};  // glyph column 0 is blank
    vecs[9]  = '{10'd559, 10'd24, 1'b1, 1'b0};  // left of box
    vecs[10] = '{10'd592, 10'd24, 1'b1, 1'b0};  // right of box
    vecs[11] = '{10'd584, 10'd15, 1'b1, 1'b0};  // above box
    vecs[12] = '{10'd584, 10'd48, 1'b1, 1'b0};  // below box
    vecs[13] = '{10'd589, 10'd24, 1'b1, 1'b1};  // odd x still maps to column 6
    vecs[14] = '{10'd577, 10'd24, 1'b1, 1'b0};  // odd x maps to column 0
    vecs[15] = '{10'd578, 10'd24, 1'b0, 1'b0};  // lit pixel but not valid
    vecs[16] = '{10'd583, 10'd25, 1'b1, 1'b0};  // row 4 col 3 of "0" is dark

    bus.frame_start = 1'b0;
    bus.digit_1     = 4'd0;
    bus.digit_2     = 4'd0;
    bus.DrawX       = 10'd0;
    bus.DrawY       = 10'd0;
    bus.pixel_valid = 1'b0;
    Reset_n         = 1'b1;
    phase           = 3'd0;

    // Reset state.
    #2 Reset_n = 1'b0;
    #1;
    check("reset_is_score", int'(bus.is_score), 0);
    check("reset_score_valid", int'(bus.score_valid), 0);
    check("reset_blinking", int'(bus.blinking), 0);
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1'b1;

    // Score 00: ones shows "0", tens blanked, no flash.
    frame(4'd0, 4'd0);
    check("zero_blinking", int'(bus.blinking), 0);
    scan_cell(576, 16, cnt);
    check("zero_ones_has_pixels", int'(cnt > 0), 1);
    scan_cell(560, 16, cnt);
    check("zero_tens_lit_count", cnt, 0);
    pix_at(10'd578, 10'd24, 1'b1, lit, sv);
    check("zero_ones_f_stroke", int'(lit), 1);

    // Mid-frame digit change must not show until the next frame_start.
    do_reset();
    frame(4'd0, 4'd3);
    bus.digit_1 = 4'd4;
    repeat (3) @(posedge Clk);
    #1;
    pix_at(10'd582, 10'd18, 1'b1, lit, sv);
    check("tear_still_3", int'(lit), 1);
    frame(4'd0, 4'd4);
    pix_at(10'd582, 10'd18, 1'b1, lit, sv);
    check("tear_now_4", int'(lit), 0);
    check("tear_blinking", int'(bus.blinking), 1);

    // Two-cycle latency on a known lit pixel of "1" (phase 1, not suppressed).
    do_reset();
    frame(4'd0, 4'd1);
    bus.DrawX       = 10'd588;
    bus.DrawY       = 10'd24;
    bus.pixel_valid = 1'b1;
    @(posedge Clk);
    #1;
    check("lat_t1_is_score", int'(bus.is_score), 0);
    bus.pixel_valid = 1'b0;
    @(posedge Clk);
    #1;
    check("lat_t2_is_score", int'(bus.is_score), 1);
    check("lat_t2_score_valid", int'(bus.score_valid), 1);
    @(posedge Clk);
    #1;
    check("lat_t3_is_score", int'(bus.is_score), 0);
    pix_at(10'd588, 10'd24, 1'b0, lit, sv);
    check("lat_invalid_is_score", int'(lit), 0);
    check("lat_invalid_score_valid", int'(sv), 0);

    // Blank ones digit (12) with tens 5.
    do_reset();
    frame(4'd5, 4'd12);
    scan_cell(576, 16, cnt);
    check("blank_ones_lit_count", cnt, 0);
    pix_at(10'd562, 10'd24, 1'b1, lit, sv);
    check("five_f_stroke", int'(lit), 1);
    pix_at(10'd572, 10'd24, 1'b1, lit, sv);
    check("five_no_b_stroke", int'(lit), 0);

    // Flash: 09 then five steady frames, then change to 10 reloads to 30.
    do_reset();
    frame(4'd0, 4'd9);
    repeat (5) frame(4'd0, 4'd9);
    check("blink_mid_count", int'(bus.blinking), 1);
    frame(4'd1, 4'd0);
    check("blink_after_change", int'(bus.blinking), 1);
    pix_at(10'd572, 10'd24, 1'b1, lit, sv);
    check("blink_phase7_suppressed", int'(lit), 0);
    for (int i = 1; i <= 30; i++) begin
      int   exp_cnt;
      logic exp_lit;
      frame(4'd1, 4'd0);
      exp_cnt = 30 - i;
      exp_lit = !((exp_cnt != 0) && phase[2]);
      check($sformatf("blink_flag_%0d", i), int'(bus.blinking), int'(exp_cnt != 0));
      pix_at(10'd572, 10'd24, 1'b1, lit, sv);
      check($sformatf("blink_pixel_%0d", i), int'(lit), int'(exp_lit));
    end

    // Steady "10" (phase 5, no flash): table of pixels streamed back-to-back.
    for (int k = 0; k <= 17; k++) begin
      if (k < 17) begin
        bus.DrawX       = vecs[k].x;
        bus.DrawY       = vecs[k].y;
        bus.pixel_valid = vecs[k].v;
      end else begin
        bus.pixel_valid = 1'b0;
      end
      @(posedge Clk);
      #1;
      if (k >= 1) begin
        check($sformatf("vec%0d_is_score", k - 1), int'(bus.is_score), int'(vecs[k - 1].exp));
        check($sformatf("vec%0d_score_valid", k - 1), int'(bus.score_valid),
              int'(vecs[k - 1].v));
      end
    end

    // Async reset with a full pipeline and an active flash.
    frame(4'd1, 4'd2);
    while (phase[2]) frame(4'd1, 4'd2);
    bus.DrawX       = 10'd572;
    bus.DrawY       = 10'd24;
    bus.pixel_valid = 1'b1;
    @(posedge Clk);
    @(posedge Clk);
    #1;
    check("pre_rst_is_score", int'(bus.is_score), 1);
    check("pre_rst_score_valid", int'(bus.score_valid), 1);
    check("pre_rst_blinking", int'(bus.blinking), 1);
    #2 Reset_n = 1'b0;
    #1;
    check("rst_is_score", int'(bus.is_score), 0);
    check("rst_score_valid", int'(bus.score_valid), 0);
    check("rst_blinking", int'(bus.blinking), 0);
    @(posedge Clk);
    #1;
    check("rst_held_is_score", int'(bus.is_score), 0);
    bus.pixel_valid = 1'b0;
    Reset_n         = 1'b1;
    @(posedge Clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/score_renderer.md
Name: score_renderer

Overview:
- Display-side consumer of the two BCD score digits from the kill/points counter.
- Snapshots the digits once per frame and renders them as a scaled 8x16 glyph overlay for the VGA colour mapper.
- Flashes the score for a fixed number of frames after the value changes.
- Sits between the points counter and the colour mapper; drives a per-pixel "score here" flag.

Parameters:
- X_POS, 10'd560, left edge of the score box in pixels.
- Y_POS, 10'd16, top edge of the score box in pixels.
- SCALE_SHIFT, 1, glyph scale factor = 2^SCALE_SHIFT (1 gives 16x32 cells); legal values 0..2.
- BLINK_FRAMES, 6'd30, number of frames the score flashes after a value change; must be ≥1.

Ports:
- Clk  in  1  system clock (50 MHz).
- Reset_n  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle pulse at the start of vertical blank.
- digit_1  in  4  ones digit, BCD.
- digit_2  in  4  tens digit, BCD.
- DrawX  in  10  current pixel column.
- DrawY  in  10  current pixel row.
- pixel_valid  in  1  DrawX/DrawY carry a visible pixel this cycle.
- is_score  out  1  pixel belongs to a lit score glyph; 2-cycle latency.
- score_valid  out  1  pixel_valid delayed 2 cycles, aligned with is_score.
- blinking  out  1  flash window is active.

Behaviour:
- Async reset (Reset_n low):
  - Shadow digits, previous snapshot, blink counter, frame phase and all pipeline registers clear to 0.
  - is_score, score_valid and blinking go to 0 immediately, not on the next clock.
- Snapshot:
  - On a cycle with frame_start=1, shadow_1 <= digit_1 and shadow_2 <= digit_2.
  - Between pulses the shadows hold, so digit changes mid-frame never tear the display.
- Change detect and blink counter (frame_start cycles only):
  - If the new snapshot differs from the current shadow, blink_cnt <= BLINK_FRAMES.
  - Else if blink_cnt != 0, blink_cnt <= blink_cnt-1.
  - A change arriving while already flashing reloads the counter; it does not extend it additively.
- Frame phase:
  - 3-bit frame_phase increments on every frame_start, wrapping 7 -> 0.
  - blinking = (blink_cnt != 0).
  - Glyphs are suppressed when blinking=1 and frame_phase[2]=1, giving a 4-on/4-off flash.
- Glyph selection:
  - Shadow values 10..15 render the blank glyph (index 10).
  - The tens digit renders blank when it is 0 (leading-zero blanking). The ones digit always renders, so a score of 00 displays "0".
- Geometry:
  - Cell width W = 8<<SCALE_SHIFT, cell height H = 16<<SCALE_SHIFT.
  - Box spans X_POS..X_POS+2W-1 and Y_POS..Y_POS+H-1; the tens cell is on the left.
  - Column within glyph = (DrawX-X_POS-cell offset)>>SCALE_SHIFT.
  - Row within glyph = (DrawY-Y_POS)>>SCALE_SHIFT.
  - Subtraction uses 10 bits, with an in-box check before use, so no wrap artefacts appear left of or above the box.
- Pipeline, 3 register stages, 2-cycle latency:
  - S0 (combinational from inputs, registered at the end of cycle t): in_box, glyph index, row[3:0], col[2:0], pixel_valid.
  - S1 (cycle t+1): synchronous font ROM read at address {glyph, row}; col, in_box and valid are delayed alongside.
  - S2 (registered at t+2): is_score = valid & in_box & rom_byte[7-col] & ~suppress; score_valid = valid.
  - When pixel_valid=0, is_score must be 0 at the aligned output cycle.
- Simultaneous events: frame_start while pixels stream is legal. The new shadow applies to S0 from the cycle after the pulse; pixels already in the pipeline keep the glyphs they started with.
- No back-pressure; the block accepts one pixel every clock.

Decomposition:
- Shared package score_pkg:
  - GLYPH_W = 8, GLYPH_H = 16, GLYPH_BLANK = 4'd10.
  - Typedef bcd_t (logic [3:0]).
  - Typedef glyph_addr_t (logic [7:0]).
- Sub-module score_font_rom:
  - 256x8 synchronous ROM, 1-cycle read latency, no reset.
  - Glyphs 0-9 are digits, glyph 10 is all zeros; addresses above 175 read zero.

Test Plan:
- Reset, then frame_start with digits 0/0; scan the box -> the ones cell shows "0", the tens cell has no lit pixels, blinking=0.
- Change digit_1 from 3 to 4 mid-frame with no frame_start -> the rendered ones glyph stays "3" until the next frame_start pulse.
- Hold one pixel known lit in glyph "1" with pixel_valid=1 at cycle t -> is_score=1 exactly at t+2 and 0 at t+1; with pixel_valid=0 the same pixel gives is_score=0.
- Snapshot changes 09 -> 10 -> blink_cnt=30 and blinking=1.
  - Glyphs are suppressed on frames with frame_phase[2]=1.
  - After 30 further frame_starts without a change, blinking=0 and the display is steady "10".
- digit_1=4'd12 with digit_2=4'd5 -> the tens cell shows "5" and the ones cell is entirely blank.
- Assert Reset_n low between clock edges while the pipeline is full -> is_score, score_valid and blinking drop to 0 immediately.
